// File: rtl/output_port_rr_allocator.sv
// Output-port allocator: decodes input header nibbles, grants one input per packet using
// two-class round-robin, and force-releases after MAX_BEATS payload beats. Optional: OPRA_AGING_EN.
module output_port_rr_allocator #(
  parameter  int PORTS     = 4,
  parameter  int MAX_BEATS = 16,
  parameter  int AGE_LIMIT = 8,
  localparam int PW        = (PORTS > 1) ? $clog2(PORTS) : 1,
  localparam int BW        = $clog2(MAX_BEATS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PW-1:0]         r_adr,
  input  logic [PORTS-1:0][3:0] in_ch_hdr_msn,
  input  logic [PORTS-1:0]      priority_field,
  output logic [PORTS-1:0]      sel,
  output logic                  shift,
  output logic                  busy,
  output logic [PW-1:0]         owner,
  output logic                  wdog_err
);

  localparam logic [1:0] TYP_HDR = 2'b11;
  localparam logic [1:0] TYP_PAY = 2'b10;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state;
  logic [PW-1:0]     owner_q;
  logic [PW-1:0]     rr_ptr;
  logic [BW-1:0]     beat_cnt;

  logic [PORTS-1:0]  req;
  logic [PORTS-1:0]  hi;
  logic [PORTS-1:0]  cand;
  logic [PW-1:0]     winner;
  logic              found;
  logic [1:0]        owner_typ;
  logic              beats_full;
  logic              release_c;
  logic              wdog_c;
  logic              avail;
  logic              grant;

  if (MAX_BEATS < 1) begin : g_bad_max_beats
    $error("MAX_BEATS must be >= 1");
  end
  if (AGE_LIMIT < 1) begin : g_bad_age_limit
    $error("AGE_LIMIT must be >= 1");
  end

  always_comb begin
    req = '0;
    for (int i = 0; i < PORTS; i++) begin
      req[i] = (in_ch_hdr_msn[i][3:2] == TYP_HDR) &&
               (int'(in_ch_hdr_msn[i][1:0]) == int'(r_adr));
    end
  end

`ifdef OPRA_AGING_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);

  logic [PORTS-1:0][AW-1:0] wait_cnt;

  // A requester that has waited AGE_LIMIT cycles competes in the high class.
  always_comb begin
    hi = '0;
    for (int i = 0; i < PORTS; i++) begin
      hi[i] = req[i] && (priority_field[i] || (wait_cnt[i] == AW'(AGE_LIMIT)));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PORTS; i++) begin
      if (rst) begin
        wait_cnt[i] <= '0;
      end else if (!req[i] || (grant && (winner == PW'(i)))) begin
        wait_cnt[i] <= '0;
      end else if (wait_cnt[i] != AW'(AGE_LIMIT)) begin
        wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end
`else
  always_comb begin
    hi = req & priority_field;
  end
`endif

  assign owner_typ  = in_ch_hdr_msn[owner_q][3:2];
  assign beats_full = (beat_cnt == BW'(MAX_BEATS));
  assign release_c  = (state == HOLD) && ((owner_typ != TYP_PAY) || beats_full);
  assign wdog_c     = (state == HOLD) && (owner_typ == TYP_PAY) && beats_full;
  assign avail      = (state == IDLE) || release_c;
  assign grant      = !rst && avail && (|req);

  // Cyclic search starting at rr_ptr over the active class.
  always_comb begin
    cand   = (|hi) ? hi : req;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      automatic int idx = (int'(rr_ptr) + k) % PORTS;
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  always_comb begin
    sel = '0;
    if (grant) begin
      sel = PORTS'(1) << winner;
    end else if (!rst && (state == HOLD) && !release_c) begin
      sel = PORTS'(1) << owner_q;
    end
  end

  assign shift    = grant;
  assign busy     = !rst && (state == HOLD);
  assign wdog_err = !rst && wdog_c;
  assign owner    = grant ? winner : owner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner_q  <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else if (grant) begin
      state    <= HOLD;
      owner_q  <= winner;
      rr_ptr   <= (winner == PW'(PORTS - 1)) ? '0 : winner + 1'b1;
      beat_cnt <= '0;
    end else if (release_c) begin
      state    <= IDLE;
    end else if ((state == HOLD) && !beats_full) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  a_sel_onehot0 : assert property (@(posedge clk) $onehot0(sel));
  a_shift_sel   : assert property (@(posedge clk) shift |-> $onehot(sel));

endmodule
